// File: rtl/i2c_expander_scheduler.sv
// i2c_expander_scheduler: round-robin sharing of one I2C expander write engine between N_REQ requesters
module i2c_expander_scheduler #(
    parameter int          N_REQ          = 4,
    parameter int          MAX_RETRIES    = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd250000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_fmc_loc,
    input  logic [8*N_REQ-1:0]   req_channel_sel,
    input  logic [8*N_REQ-1:0]   req_ctrl_reg,
    output logic [N_REQ-1:0]     req_busy,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_error,
    output logic                 sm_start,
    input  logic                 sm_running,
    output logic [1:0]           fmc_loc,
    output logic [7:0]           channel_sel,
    output logic [7:0]           ctrl_reg,
    input  logic                 write_done,
    input  logic                 write_error,
    output logic                 sched_busy
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, RETRY, REPORT} state_t;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   pending;
    logic [N_REQ-1:0]   gnt_mask;
    logic [17:0]        shadow [N_REQ];
    logic [PW-1:0]      ptr, g, gnt_idx, idx;
    logic               gnt_found;
    logic [7:0]         retry_cnt;
    logic [23:0]        tmo_cnt;
    logic               report_err;
    logic               do_grant, do_start, tmo_hit, retry_ok;

    assign tmo_hit  = tmo_cnt == TIMEOUT_CYCLES - 24'd1;
    assign retry_ok = retry_cnt < 8'(MAX_RETRIES);
    assign gnt_mask = do_grant ? N_REQ'(1) << gnt_idx : '0;

    // First pending slot at or after ptr; scanning downwards lets the closest one win
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (pending[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a write error takes precedence over a simultaneous done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = gnt_found ? START : IDLE;
            START:     state_nxt = sm_running ? START : WAIT_DONE;
            WAIT_DONE: state_nxt = write_error ? RETRY : (write_done || tmo_hit) ? REPORT : WAIT_DONE;
            RETRY:     state_nxt = retry_ok ? START : REPORT;
            REPORT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Strobes and per-requester status, decoded from the current state
    always_comb begin
        do_grant   = (state == IDLE) && gnt_found;
        do_start   = (state == START) && !sm_running;
        sched_busy = state != IDLE;
        req_busy   = pending;
        req_done   = '0;
        req_error  = '0;
        if (state != IDLE) req_busy[g] = 1'b1;
        if (state == REPORT) begin
            req_done[g]  = !report_err;
            req_error[g] = report_err;
        end
    end

    // Request capture: a new request always overwrites the shadow and re-pends, even over a grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int i = 0; i < N_REQ; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (req[i]) shadow[i] <= {req_fmc_loc[2*i +: 2], req_channel_sel[8*i +: 8], req_ctrl_reg[8*i +: 8]};
            pending <= (pending & ~gnt_mask) | req;
        end
    end

    // Grant data, start pulse, retry/timeout counters and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sm_start    <= 1'b0;
            g           <= '0;
            ptr         <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            report_err  <= 1'b0;
            fmc_loc     <= '0;
            channel_sel <= '0;
            ctrl_reg    <= '0;
        end else begin
            sm_start <= do_start;
            if (do_grant) begin
                g                                <= gnt_idx;
                {fmc_loc, channel_sel, ctrl_reg} <= shadow[gnt_idx];
                retry_cnt                        <= '0;
            end
            if (do_start) tmo_cnt <= '0;
            else if (state == WAIT_DONE && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 24'd1;
            if (state == RETRY && retry_ok) retry_cnt <= retry_cnt + 8'd1;
            if (state == WAIT_DONE) report_err <= !write_done;
            if (state == RETRY) report_err <= 1'b1;
            if (state == REPORT) ptr <= (g == PW'(N_REQ - 1)) ? '0 : g + 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_expander_scheduler.sv
// tb_i2c_expander_scheduler: directed latency/corner tests plus randomized traffic against a transaction-level model
module tb_i2c_expander_scheduler;
    localparam int N    = 4;
    localparam int MAXR = 2;
    localparam int TMO  = 100;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_fmc_loc = '0;
    logic [8*N-1:0] req_channel_sel = '0;
    logic [8*N-1:0] req_ctrl_reg = '0;
    logic [N-1:0]   req_busy, req_done, req_error;
    logic           sm_start, sched_busy;
    logic           sm_running = 1'b0;
    logic           write_done = 1'b0;
    logic           write_error = 1'b0;
    logic [1:0]     fmc_loc;
    logic [7:0]     channel_sel, ctrl_reg;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_pend [N];
    logic [17:0] m_data [N];
    int          m_ptr;

    i2c_expander_scheduler #(.N_REQ(N), .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(24'(TMO))) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_fmc_loc(req_fmc_loc),
        .req_channel_sel(req_channel_sel), .req_ctrl_reg(req_ctrl_reg), .req_busy(req_busy),
        .req_done(req_done), .req_error(req_error), .sm_start(sm_start), .sm_running(sm_running),
        .fmc_loc(fmc_loc), .channel_sel(channel_sel), .ctrl_reg(ctrl_reg),
        .write_done(write_done), .write_error(write_error), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic post(input int i, input logic [17:0] d);
        req[i] = 1'b1;
        req_fmc_loc[2*i +: 2] = d[17:16];
        req_channel_sel[8*i +: 8] = d[15:8];
        req_ctrl_reg[8*i +: 8] = d[7:0];
    endtask

    task automatic post_m(input int i, input logic [17:0] d);
        post(i, d);
        m_pend[i] = 1'b1;
        m_data[i] = d;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic wait_start(input string tag, input int max);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < max && !seen; n++) begin
            step();
            req = '0;
            write_done = 1'b0;
            write_error = 1'b0;
            seen = sm_start;
        end
        check(tag, 32'(seen), 32'(1));
    endtask

    task automatic run_random(input int ncyc);
        bit          act, prev_start, forced, ok;
        int          g, e, att, dly, tail, txn, n, bursts;
        logic [17:0] cur;
        logic [N-1:0] mask;
        int          order_q [$];
        int          fixed_e [4] = '{2, 3, 0, 1};
        int          exp_order [5] = '{0, 1, 2, 3, 0};
        act = 0; prev_start = 0; forced = 0;
        g = 0; e = 0; att = 0; dly = 0; tail = 0; txn = 0; n = 0; bursts = 0; cur = '0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        while (n < ncyc || ((act || pick() >= 0 || dly > 0 || tail > 0) && n < ncyc + 5000)) begin
            step();
            n++;
            req = '0;
            write_done = 1'b0;
            write_error = 1'b0;
            if (sm_start) begin
                check("start_gap", 32'(prev_start), 32'(0));
                if (!act) begin
                    g = pick();
                    check("start_has_request", 32'(g >= 0), 32'(1));
                    if (g < 0) g = 0;
                    m_pend[g] = 1'b0;
                    cur = m_data[g];
                    act = 1;
                    att = 0;
                    e = (txn < 4) ? fixed_e[txn] : int'($urandom_range(0, MAXR + 1));
                    txn++;
                end
                att++;
                check("write_data", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'(cur));
                dly = $urandom_range(2, 6);
                sm_running = 1'b1;
            end
            prev_start = sm_start;
            if ((req_done | req_error) != 0) begin
                if (!act) check("unexpected_report", 32'({req_done, req_error}), 32'(0));
                else begin
                    ok = e <= MAXR;
                    check("report_done", 32'(req_done), ok ? 32'(1) << g : 32'(0));
                    check("report_error", 32'(req_error), ok ? 32'(0) : 32'(1) << g);
                    check("attempts", 32'(att), ok ? 32'(e + 1) : 32'(MAXR + 1));
                    check("report_busy", 32'(req_busy), 32'(pend_vec()) | (32'(1) << g));
                    check("data_hold", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'(cur));
                    order_q.push_back(g);
                    m_ptr = (g + 1) % N;
                    act = 0;
                end
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    if (att <= e) begin
                        write_error = 1'b1;
                        write_done = ($urandom_range(0, 3) == 0);
                    end else write_done = 1'b1;
                    tail = $urandom_range(0, 3);
                    sm_running = (tail != 0);
                end else if (txn == 2 && g == 1 && !forced) begin
                    post_m(0, {2'd2, 8'h55, 8'hAA});
                    forced = 1;
                end else if (txn >= 5 && $urandom_range(0, 3) == 0)
                    post_m(int'($urandom_range(0, N - 1)), 18'($urandom));
            end else if (tail > 0) begin
                tail--;
                sm_running = (tail != 0);
            end else if (n < ncyc && !act && pick() < 0 && $urandom_range(0, 2) == 0) begin
                bursts++;
                mask = (bursts == 1) ? '1 : N'($urandom_range(1, 2**N - 1));
                for (int i = 0; i < N; i++)
                    if (mask[i]) post_m(i, (bursts == 1) ? {2'(i), 8'(1 << i), 8'(8'h10 + i)} : 18'($urandom));
            end
        end
        check("drained", 32'(act || pick() >= 0), 32'(0));
        check("order_count", 32'(order_q.size() >= 5), 32'(1));
        if (order_q.size() >= 5)
            for (int k = 0; k < 5; k++) check("fair_order", 32'(order_q[k]), 32'(exp_order[k]));
    endtask

    initial begin
        logic [N-1:0] acc;
        logic         acc_s, seen;
        int           n;

        repeat (3) step();
        check("rst_sm_start", 32'(sm_start), 32'(0));
        check("rst_sched_busy", 32'(sched_busy), 32'(0));
        check("rst_status", 32'({req_busy, req_done, req_error}), 32'(0));
        check("rst_data", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'(0));
        reset_n = 1'b1;
        step();

        post(2, {2'd1, 8'h04, 8'hA5});
        step();
        req = '0;
        check("busy_c1", 32'(req_busy), 32'(4'b0100));
        check("sm_start_c1", 32'(sm_start), 32'(0));
        step();
        check("sm_start_c2", 32'(sm_start), 32'(0));
        step();
        check("sm_start_c3", 32'(sm_start), 32'(1));
        check("single_data", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'({2'd1, 8'h04, 8'hA5}));
        sm_running = 1'b1;
        step();
        check("sm_start_c4", 32'(sm_start), 32'(0));
        step();
        step();
        check("single_hold", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'({2'd1, 8'h04, 8'hA5}));
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("single_done", 32'(req_done), 32'(4'b0100));
        check("single_no_error", 32'(req_error), 32'(0));
        check("single_busy_report", 32'(req_busy), 32'(4'b0100));
        step();
        check("single_done_once", 32'(req_done), 32'(0));
        check("single_busy_clear", 32'(req_busy), 32'(0));
        check("single_idle", 32'(sched_busy), 32'(0));
        sm_running = 1'b0;

        post(0, {2'd0, 8'h01, 8'h30});
        wait_start("coal_start0", 5);
        sm_running = 1'b1;
        post(1, {2'd2, 8'h02, 8'h11});
        step();
        req = '0;
        post(1, {2'd2, 8'h02, 8'h22});
        step();
        req = '0;
        check("coal_busy", 32'(req_busy), 32'(4'b0011));
        step();
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("coal_done0", 32'(req_done), 32'(4'b0001));
        sm_running = 1'b0;
        wait_start("coal_start1", 6);
        check("coal_data", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'({2'd2, 8'h02, 8'h22}));
        sm_running = 1'b1;
        step();
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("coal_done1", 32'(req_done), 32'(4'b0010));
        sm_running = 1'b0;
        acc_s = 1'b0;
        repeat (20) begin
            step();
            acc_s |= sm_start;
        end
        check("coal_single_write", 32'(acc_s), 32'(0));
        check("coal_busy_clear", 32'(req_busy), 32'(0));

        post(1, {2'd3, 8'h02, 8'h5C});
        wait_start("tmo_start", 5);
        sm_running = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            step();
            n++;
            seen = (req_error != 0);
        end
        check("tmo_latency", 32'(n), 32'(TMO));
        check("tmo_error_bit", 32'(req_error), 32'(4'b0010));
        check("tmo_no_done", 32'(req_done), 32'(0));
        step();
        step();
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        acc = '0;
        repeat (5) begin
            step();
            acc |= req_done | req_error;
        end
        check("late_done_ignored", 32'(acc), 32'(0));
        post(3, {2'd0, 8'h80, 8'h3C});
        acc_s = 1'b0;
        repeat (10) begin
            step();
            req = '0;
            acc_s |= sm_start;
        end
        check("start_waits_running", 32'(acc_s), 32'(0));
        check("waiting_busy", 32'(sched_busy), 32'(1));
        sm_running = 1'b0;
        wait_start("start_after_idle", 3);
        check("tmo_next_data", 32'(ctrl_reg), 32'(8'h3C));
        sm_running = 1'b1;
        step();
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("tmo_next_done", 32'(req_done), 32'(4'b1000));
        step();
        sm_running = 1'b0;

        post(0, {2'd1, 8'h10, 8'h77});
        wait_start("rst_mid_start", 5);
        sm_running = 1'b1;
        post(2, {2'd2, 8'h20, 8'h66});
        step();
        req = '0;
        write_error = 1'b1;
        step();
        write_error = 1'b0;
        sm_running = 1'b0;
        wait_start("rst_mid_retry", 5);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_start", 32'(sm_start), 32'(0));
        check("rst_async_busy", 32'({sched_busy, req_busy}), 32'(0));
        check("rst_async_data", 32'({fmc_loc, channel_sel, ctrl_reg}), 32'(0));
        step();
        step();
        reset_n = 1'b1;
        acc = '0;
        acc_s = 1'b0;
        repeat (20) begin
            step();
            acc |= req_done | req_error | req_busy;
            acc_s |= sm_start;
        end
        check("rst_no_report", 32'(acc), 32'(0));
        check("rst_no_start", 32'(acc_s), 32'(0));

        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
